// File: rtl/alu_pkg.sv
// Shared opcode, operand-type and controller-state encodings for the ALU complex.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_MUL = 4'h2;
    localparam logic [3:0] OP_DIV = 4'h3;
    localparam logic [3:0] OP_AND = 4'h4;
    localparam logic [3:0] OP_OR  = 4'h5;
    localparam logic [3:0] OP_XOR = 4'h6;
    localparam logic [3:0] OP_SHL = 4'h7;
    localparam logic [3:0] OP_SHR = 4'h8;
    localparam logic [3:0] OP_SLT = 4'h9;
    localparam logic [3:0] OP_PB  = 4'hA;
    localparam logic [3:0] OP_NOP = 4'hF;

    localparam logic [1:0] TYPE_SIGNED = 2'd0;
    localparam logic [1:0] TYPE_BYTE   = 2'd1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    typedef struct packed {
        logic [3:0]  op;
        logic [1:0]  typ;
        logic [15:0] a;
        logic [15:0] b;
    } alu_op_t;

    typedef enum logic [1:0] {
        ROUTE_ALU,
        ROUTE_ERR,
        ROUTE_NOP
    } route_e;

    // Decides whether an accepted operation needs the ALU or is answered locally.
    function automatic route_e classify(input logic [3:0] op, input logic [15:0] b);
        if (op == OP_NOP) return ROUTE_NOP;
        if (op > OP_PB) return ROUTE_ERR;
        if ((op == OP_DIV) && (b == 16'h0000)) return ROUTE_ERR;
        return ROUTE_ALU;
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Requester and ALU-side signal bundle of the ALU issue controller.
interface alu_issue_ctrl_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]    req_valid_i;
    logic [NUM_REQ-1:0]    req_ready_o;
    logic [4*NUM_REQ-1:0]  req_op_i;
    logic [2*NUM_REQ-1:0]  req_type_i;
    logic [16*NUM_REQ-1:0] req_a_i;
    logic [16*NUM_REQ-1:0] req_b_i;
    logic [NUM_REQ-1:0]    rsp_valid_o;
    logic [NUM_REQ-1:0]    rsp_ready_i;
    logic [15:0]           rsp_result_o;
    logic                  rsp_error_o;
    logic                  alu_en_o;
    logic [3:0]            alu_op_o;
    logic [1:0]            alu_type_o;
    logic [15:0]           alu_a_o;
    logic [15:0]           alu_b_o;
    logic [15:0]           alu_result_i;
    logic                  alu_error_i;

    modport slave (
        input  req_valid_i, req_op_i, req_type_i, req_a_i, req_b_i, rsp_ready_i,
               alu_result_i, alu_error_i,
        output req_ready_o, rsp_valid_o, rsp_result_o, rsp_error_o,
               alu_en_o, alu_op_o, alu_type_o, alu_a_o, alu_b_o
    );

    modport master (
        output req_valid_i, req_op_i, req_type_i, req_a_i, req_b_i, rsp_ready_i,
               alu_result_i, alu_error_i,
        input  req_ready_o, rsp_valid_o, rsp_result_o, rsp_error_o,
               alu_en_o, alu_op_o, alu_type_o, alu_a_o, alu_b_o
    );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          grant_any
);
    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int offset);
        int sum;
        sum = int'(base) + offset;
        if (sum >= N) sum = sum - N;
        return sum[IW-1:0];
    endfunction

    logic [IW-1:0] cand [N];

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_cand
            assign cand[gi] = wrap_add(ptr, gi);
        end
    endgenerate

    // Scan from the farthest candidate down so the nearest one to ptr wins.
    always_comb begin
        grant_idx = '0;
        grant_any = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[cand[i]]) begin
                grant_idx = cand[i];
                grant_any = 1'b1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_grant
            assign grant[gi] = grant_any && (grant_idx == IW'(gi));
        end
    endgenerate
endmodule

// File: rtl/alu_issue_ctrl.sv
// Shares one multi-cycle ALU between NUM_REQ requesters, one operation at a time,
// answering NOP, illegal opcodes and divide-by-zero locally.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ALU_LAT = 1
) (
    input logic             clk_i,
    input logic             rst_ni,
    alu_issue_ctrl_if.slave bus
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(ALU_LAT + 1);

    logic [1:0]    state_reg;
    logic [IW-1:0] ptr_reg;
    logic [IW-1:0] gidx_reg;
    alu_op_t       op_reg;
    logic [CW-1:0] cnt_reg;
    logic [15:0]   result_reg;
    logic          error_reg;

    alu_op_t       req_arr [NUM_REQ];
    logic [NUM_REQ-1:0] grant;
    logic [IW-1:0] grant_idx;
    logic          grant_any;
    logic [IW-1:0] ptr_next;
    alu_op_t       sel_op;
    route_e        route;
    logic          in_alu;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign req_arr[gi] = {bus.req_op_i[4*gi +: 4], bus.req_type_i[2*gi +: 2],
                                  bus.req_a_i[16*gi +: 16], bus.req_b_i[16*gi +: 16]};
        end
    endgenerate

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req       (bus.req_valid_i),
        .ptr       (ptr_reg),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    assign ptr_next = (grant_idx == IW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    assign sel_op   = req_arr[grant_idx];
    assign route    = classify(sel_op.op, sel_op.b);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg  <= ST_IDLE;
            ptr_reg    <= '0;
            gidx_reg   <= '0;
            op_reg     <= '0;
            cnt_reg    <= '0;
            result_reg <= '0;
            error_reg  <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (grant_any) begin
                        op_reg     <= sel_op;
                        gidx_reg   <= grant_idx;
                        ptr_reg    <= ptr_next;
                        result_reg <= '0;
                        error_reg  <= (route == ROUTE_ERR);
                        state_reg  <= (route == ROUTE_ALU) ? ST_ISSUE : ST_RESP;
                    end
                end
                ST_ISSUE: begin
                    cnt_reg   <= CW'(ALU_LAT);
                    state_reg <= ST_WAIT;
                end
                ST_WAIT: begin
                    // The ALU result is only trusted on the final count edge.
                    if (cnt_reg == CW'(1)) begin
                        result_reg <= bus.alu_result_i;
                        error_reg  <= bus.alu_error_i;
                        state_reg  <= ST_RESP;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready_i[gidx_reg]) state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign in_alu = (state_reg == ST_ISSUE) || (state_reg == ST_WAIT);

    assign bus.req_ready_o  = ((state_reg == ST_IDLE) && rst_ni) ? grant : '0;
    assign bus.rsp_result_o = (state_reg == ST_RESP) ? result_reg : '0;
    assign bus.rsp_error_o  = (state_reg == ST_RESP) && error_reg;
    assign bus.alu_en_o     = (state_reg == ST_ISSUE);
    assign bus.alu_op_o     = in_alu ? op_reg.op  : '0;
    assign bus.alu_type_o   = in_alu ? op_reg.typ : '0;
    assign bus.alu_a_o      = in_alu ? op_reg.a   : '0;
    assign bus.alu_b_o      = in_alu ? op_reg.b   : '0;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rsp
            assign bus.rsp_valid_o[gi] = (state_reg == ST_RESP) && (gidx_reg == IW'(gi));
        end
    endgenerate
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl: ALU_LAT=1 and ALU_LAT=3 instances with a latency-aware ALU model.
module tb_alu_issue_ctrl;
    import alu_pkg::*;

    typedef struct packed {
        logic [1:0]  port;
        logic [15:0] res;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   compared = 0;
    int   mismatched = 0;
    int   en_cnt1 = 0;
    int   en_hs = 0;
    int   age1 = 0;
    int   age3 = 0;
    logic [16:0] hold1 = '0;
    logic [16:0] hold3 = '0;
    exp_t q1[$];
    exp_t q3[$];
    exp_t m1;
    exp_t m3;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_issue_ctrl_if #(.NUM_REQ(2)) bus1 ();
    alu_issue_ctrl_if #(.NUM_REQ(2)) bus3 ();

    alu_issue_ctrl #(.NUM_REQ(2), .ALU_LAT(1)) dut1 (.clk_i(clk), .rst_ni(rst_n), .bus(bus1));
    alu_issue_ctrl #(.NUM_REQ(2), .ALU_LAT(3)) dut3 (.clk_i(clk), .rst_ni(rst_n), .bus(bus3));

    function automatic logic [16:0] alu_model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            OP_ADD:  return {1'b0, a + b};
            OP_SUB:  return {1'b0, a - b};
            OP_MUL:  return {1'b0, a * b};
            OP_AND:  return {1'b0, a & b};
            default: return {1'b1, 16'h0000};
        endcase
    endfunction

    function automatic logic [1:0] onehot(input int p);
        return 2'(1 << p);
    endfunction

    // ALU models: result is garbage except in the cycle ALU_LAT after the enable pulse.
    always @(posedge clk) begin
        if (bus1.alu_en_o) begin
            age1    <= 1;
            hold1   <= alu_model(bus1.alu_op_o, bus1.alu_a_o, bus1.alu_b_o);
            en_cnt1 <= en_cnt1 + 1;
        end else if (age1 != 0 && age1 < 100) begin
            age1 <= age1 + 1;
        end
        if (bus3.alu_en_o) begin
            age3  <= 1;
            hold3 <= alu_model(bus3.alu_op_o, bus3.alu_a_o, bus3.alu_b_o);
        end else if (age3 != 0 && age3 < 100) begin
            age3 <= age3 + 1;
        end
    end
    assign bus1.alu_result_i = (age1 == 1) ? hold1[15:0] : 16'hDEAD;
    assign bus1.alu_error_i  = (age1 == 1) ? hold1[16]   : 1'b1;
    assign bus3.alu_result_i = (age3 == 3) ? hold3[15:0] : 16'hDEAD;
    assign bus3.alu_error_i  = (age3 == 3) ? hold3[16]   : 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitors: pop on every response handshake.
    always @(negedge clk) begin
        if (rst_n && ((bus1.rsp_valid_o & bus1.rsp_ready_i) != 2'b00)) begin
            check("rsp1_expected", 64'(q1.size() != 0), 64'd1);
            if (q1.size() != 0) begin
                m1 = q1.pop_front();
                check("rsp1_port", 64'(bus1.rsp_valid_o), 64'(onehot(int'(m1.port))));
                check("rsp1_result", 64'(bus1.rsp_result_o), 64'(m1.res));
                check("rsp1_error", 64'(bus1.rsp_error_o), 64'(m1.err));
                $display("dut1 rsp port=%0d result=%h error=%0b", m1.port, bus1.rsp_result_o, bus1.rsp_error_o);
            end
        end
        if (rst_n && ((bus3.rsp_valid_o & bus3.rsp_ready_i) != 2'b00)) begin
            check("rsp3_expected", 64'(q3.size() != 0), 64'd1);
            if (q3.size() != 0) begin
                m3 = q3.pop_front();
                check("rsp3_port", 64'(bus3.rsp_valid_o), 64'(onehot(int'(m3.port))));
                check("rsp3_result", 64'(bus3.rsp_result_o), 64'(m3.res));
                check("rsp3_error", 64'(bus3.rsp_error_o), 64'(m3.err));
                $display("dut3 rsp port=%0d result=%h error=%0b", m3.port, bus3.rsp_result_o, bus3.rsp_error_o);
            end
        end
    end

    task automatic to_negedge_of(input int t);
        @(negedge clk);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic issue_req(input int p, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                             input bit push, input logic [15:0] er, input logic ee, output int hs);
        if (push) q1.push_back('{port: 2'(p), res: er, err: ee});
        @(posedge clk); #1;
        bus1.req_valid_i[p]         = 1'b1;
        bus1.req_op_i[4*p +: 4]     = op;
        bus1.req_type_i[2*p +: 2]   = TYPE_SIGNED;
        bus1.req_a_i[16*p +: 16]    = a;
        bus1.req_b_i[16*p +: 16]    = b;
        hs = -1;
        for (int i = 0; i < 40 && hs < 0; i++) begin
            @(negedge clk);
            if (bus1.req_ready_o[p]) begin
                hs    = cyc;
                en_hs = en_cnt1;
            end
        end
        check("grant_seen", 64'(hs >= 0), 64'd1);
        @(posedge clk); #1;
        bus1.req_valid_i[p] = 1'b0;
    endtask

    task automatic wait_rsp(input string name, input int p, input int hs, input int exp_lat, input int exp_en);
        int seen;
        seen = -1;
        for (int i = 0; i < 40 && seen < 0; i++) begin
            @(negedge clk);
            if (bus1.rsp_valid_o != 2'b00) seen = cyc;
        end
        check({name, "_latency"}, 64'(seen - hs), 64'(exp_lat));
        check({name, "_rsp_valid"}, 64'(bus1.rsp_valid_o), 64'(onehot(p)));
        check({name, "_alu_en_count"}, 64'(en_cnt1 - en_hs), 64'(exp_en));
        check({name, "_alu_quiet"}, {bus1.alu_en_o, bus1.alu_op_o, bus1.alu_type_o, bus1.alu_a_o, bus1.alu_b_o}, 64'd0);
    endtask

    task automatic drain1();
        for (int i = 0; i < 50 && q1.size() != 0; i++) @(negedge clk);
        check("drain1", 64'(q1.size()), 64'd0);
    endtask

    initial begin
        int hs;
        int ng;
        int seen;
        logic [1:0] any_vld;
        logic [1:0] rr_exp [4];

        bus1.req_valid_i = '0; bus1.req_op_i = '0; bus1.req_type_i = '0;
        bus1.req_a_i = '0; bus1.req_b_i = '0; bus1.rsp_ready_i = 2'b11;
        bus3.req_valid_i = '0; bus3.req_op_i = '0; bus3.req_type_i = '0;
        bus3.req_a_i = '0; bus3.req_b_i = '0; bus3.rsp_ready_i = 2'b11;

        // Reset state
        repeat (2) @(negedge clk);
        check("reset_outputs1", {bus1.req_ready_o, bus1.rsp_valid_o, bus1.rsp_result_o, bus1.rsp_error_o,
                                 bus1.alu_en_o, bus1.alu_op_o, bus1.alu_type_o, bus1.alu_a_o, bus1.alu_b_o}, 64'd0);
        check("reset_outputs3", {bus3.req_ready_o, bus3.rsp_valid_o, bus3.rsp_result_o, bus3.rsp_error_o,
                                 bus3.alu_en_o, bus3.alu_op_o, bus3.alu_type_o, bus3.alu_a_o, bus3.alu_b_o}, 64'd0);
        @(posedge clk); #1; rst_n = 1'b1;

        // Reset in the middle of WAIT discards the operation
        issue_req(0, OP_ADD, 16'h0003, 16'h0004, 1'b0, 16'h0, 1'b0, hs);
        to_negedge_of(hs + 2);
        check("midwait_held", {bus1.alu_en_o, bus1.alu_op_o, bus1.alu_a_o, bus1.alu_b_o},
              {1'b0, OP_ADD, 16'h0003, 16'h0004});
        rst_n = 1'b0;
        #1;
        check("midwait_reset_outputs", {bus1.req_ready_o, bus1.rsp_valid_o, bus1.rsp_result_o, bus1.rsp_error_o,
                                        bus1.alu_en_o, bus1.alu_op_o, bus1.alu_type_o, bus1.alu_a_o, bus1.alu_b_o}, 64'd0);
        @(posedge clk); #1; rst_n = 1'b1;
        any_vld = '0;
        repeat (6) begin
            @(negedge clk);
            any_vld = any_vld | bus1.rsp_valid_o;
        end
        check("midwait_no_rsp", 64'(any_vld), 64'd0);

        // Round-robin with both ports holding valid; first grant shows the pointer is back at 0
        rr_exp[0] = 2'b01; rr_exp[1] = 2'b10; rr_exp[2] = 2'b01; rr_exp[3] = 2'b10;
        q1.push_back('{port: 2'd0, res: 16'h000F, err: 1'b0});
        q1.push_back('{port: 2'd1, res: 16'h0000, err: 1'b0});
        q1.push_back('{port: 2'd0, res: 16'h000F, err: 1'b0});
        q1.push_back('{port: 2'd1, res: 16'h0000, err: 1'b0});
        @(posedge clk); #1;
        bus1.req_op_i = {OP_AND, OP_SUB};
        bus1.req_a_i  = {16'h00F0, 16'h0010};
        bus1.req_b_i  = {16'h0F0F, 16'h0001};
        bus1.req_valid_i = 2'b11;
        ng = 0;
        for (int i = 0; i < 200 && ng < 4; i++) begin
            @(negedge clk);
            if (bus1.req_ready_o != 2'b00) begin
                check($sformatf("rr_grant%0d", ng), 64'(bus1.req_ready_o), 64'(rr_exp[ng]));
                ng++;
            end
        end
        check("rr_grant_count", 64'(ng), 64'd4);
        @(posedge clk); #1; bus1.req_valid_i = 2'b00;
        drain1();

        // Single ADD on the ALU path
        issue_req(0, OP_ADD, 16'h0003, 16'h0004, 1'b1, 16'h0007, 1'b0, hs);
        to_negedge_of(hs + 1);
        check("add_issue", {bus1.alu_en_o, bus1.alu_op_o, bus1.alu_a_o, bus1.alu_b_o},
              {1'b1, OP_ADD, 16'h0003, 16'h0004});
        wait_rsp("add", 0, hs, 3, 1);

        // Divide-by-zero on port 1 is answered locally
        issue_req(1, OP_DIV, 16'h1234, 16'h0000, 1'b1, 16'h0000, 1'b1, hs);
        wait_rsp("div0", 1, hs, 1, 0);

        // Back-pressure: response held while a second request waits
        @(posedge clk); #1; bus1.rsp_ready_i = 2'b00;
        issue_req(0, OP_MUL, 16'h0002, 16'h0003, 1'b1, 16'h0006, 1'b0, hs);
        wait_rsp("mul", 0, hs, 3, 1);
        @(posedge clk); #1;
        bus1.req_valid_i[1] = 1'b1;
        bus1.req_op_i[7:4]  = OP_NOP;
        repeat (5) begin
            @(negedge clk);
            check("bp_rsp_held", {bus1.rsp_valid_o, bus1.rsp_result_o, bus1.rsp_error_o}, {2'b01, 16'h0006, 1'b0});
            check("bp_no_grant", 64'(bus1.req_ready_o), 64'd0);
        end
        @(posedge clk); #1; bus1.rsp_ready_i = 2'b11;
        issue_req(1, OP_NOP, 16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b0, hs);
        wait_rsp("bp_nop", 1, hs, 1, 0);

        // Illegal opcode and NOP
        issue_req(0, 4'hC, 16'h0005, 16'h0006, 1'b1, 16'h0000, 1'b1, hs);
        wait_rsp("illegal", 0, hs, 1, 0);
        issue_req(1, OP_NOP, 16'h0005, 16'h0006, 1'b1, 16'h0000, 1'b0, hs);
        wait_rsp("nop", 1, hs, 1, 0);
        drain1();

        // ALU_LAT=3 instance: ADD response five cycles after the handshake
        q3.push_back('{port: 2'd0, res: 16'h0007, err: 1'b0});
        @(posedge clk); #1;
        bus3.req_valid_i = 2'b01;
        bus3.req_op_i    = {OP_NOP, OP_ADD};
        bus3.req_a_i     = {16'h0000, 16'h0003};
        bus3.req_b_i     = {16'h0000, 16'h0004};
        hs = -1;
        for (int i = 0; i < 40 && hs < 0; i++) begin
            @(negedge clk);
            if (bus3.req_ready_o[0]) hs = cyc;
        end
        check("lat3_grant_seen", 64'(hs >= 0), 64'd1);
        @(posedge clk); #1; bus3.req_valid_i = 2'b00;
        seen = -1;
        for (int i = 0; i < 40 && seen < 0; i++) begin
            @(negedge clk);
            if (bus3.rsp_valid_o != 2'b00) seen = cyc;
        end
        check("lat3_latency", 64'(seen - hs), 64'd5);
        for (int i = 0; i < 50 && q3.size() != 0; i++) @(negedge clk);
        check("drain3", 64'(q3.size()), 64'd0);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Controller that shares the single 16-bit ALU datapath between NUM_REQ requesters (decode ports, address-generation, debug).
- Arbitrates with round-robin priority and sequences exactly one operation at a time through the ALU.
- Handles ALU latency and returns the result and error flag to the granting requester.
- Screens divide-by-zero, illegal opcodes and NOP locally, without driving the ALU.

Parameters:
- NUM_REQ, 2, number of requester ports (2..4).
- ALU_LAT, 1, cycles from the alu_en_o cycle to a valid alu_result_i (>=1).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- req_valid_i  in  NUM_REQ  per-requester operation valid.
- req_ready_o  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_op_i  in  4*NUM_REQ  opcode per requester.
- req_type_i  in  2*NUM_REQ  operand type per requester (0 signed, 1 byte).
- req_a_i  in  16*NUM_REQ  operand A per requester.
- req_b_i  in  16*NUM_REQ  operand B per requester.
- rsp_valid_o  out  NUM_REQ  response valid, one-hot to the granted requester.
- rsp_ready_i  in  NUM_REQ  per-requester response accept.
- rsp_result_o  out  16  response result, shared by all requesters.
- rsp_error_o  out  1  response arithmetic/illegal error.
- alu_en_o  out  1  ALU enable, one-cycle pulse.
- alu_op_o  out  4  ALU opcode.
- alu_type_o  out  2  ALU operand type.
- alu_a_o  out  16  ALU operand A.
- alu_b_o  out  16  ALU operand B.
- alu_result_i  in  16  ALU result.
- alu_error_i  in  1  ALU error flag.

Behaviour:
- Reset (async, rst_ni=0):
  - State goes to IDLE and the RR pointer to 0.
  - All outputs are 0: req_ready_o, rsp_valid_o, rsp_result_o, rsp_error_o, alu_en_o, alu_op_o, alu_type_o, alu_a_o, alu_b_o.
  - Any in-flight operation is discarded with no response.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Grant g is the first asserted req_valid_i at or after the RR pointer, wrapping.
  - req_ready_o[g]=1 combinationally in the same cycle, and only in IDLE.
  - On that edge the controller latches op, type, a, b and g, and the pointer becomes (g+1) mod NUM_REQ.
  - The latched operation then routes as follows:
    - Normal op (0x0-0xA, excluding divide-by-zero): go to ISSUE.
    - op=0x3 with b=0: go to RESP with result 0x0000, error=1.
    - op 0xB-0xE: illegal; go to RESP with result 0x0000, error=1.
    - op=0xF (NOP): go to RESP with result 0x0000, error=0.
    - In none of these three local cases is the ALU driven.
- ISSUE:
  - alu_en_o=1 for exactly one cycle, with the latched op, type, a and b.
  - Wait counter loads ALU_LAT; go to WAIT.
- WAIT:
  - The counter decrements each cycle.
  - Operand outputs are held stable; alu_en_o=0.
  - When the counter reaches 1, capture alu_result_i and alu_error_i on that edge and go to RESP.
- RESP:
  - rsp_valid_o[g]=1; result and error are held stable until rsp_ready_i[g]=1.
  - On that handshake edge, go to IDLE. The next grant is possible one cycle later, with no back-to-back grant in the RESP exit cycle.
  - rsp_ready_i of non-granted requesters is ignored.
- Latency, handshake to rsp_valid:
  - ALU path: ALU_LAT+2 cycles (3 for default).
  - Local path (div0, illegal, NOP): 1 cycle.
- ALU outputs are zero whenever state is not ISSUE or WAIT, to avoid spurious toggling.
- Requesters must hold valid and payload until ready; dropping valid before grant is legal and simply loses arbitration.
- Simultaneous valid from all ports: strict rotation, so each port is served once per NUM_REQ grants.
- alu_error_i is sampled only on the capture edge; its value in other cycles is ignored.

Decomposition:
- Shared package alu_pkg:
  - opcode constants OP_ADD..OP_PB (0x0-0xA) and OP_NOP=0xF;
  - type constants TYPE_SIGNED=0, TYPE_BYTE=1;
  - state encoding for IDLE, ISSUE, WAIT, RESP.
  - The ALU and this controller both import it.
- Sub-module rr_arbiter (parameter N):
  - inputs: request vector, pointer;
  - outputs: one-hot grant and grant index.

Test Plan:
- Reset mid-WAIT: port0 issues ADD a=0x0003 b=0x0004, assert rst_ni=0 during WAIT -> all outputs 0 immediately; after release, no rsp_valid_o, pointer=0.
- Single ADD: port0 sends a=0x0003 b=0x0004, ALU_LAT=1 -> alu_en_o pulse 1 cycle after handshake; rsp_valid_o=01 three cycles after handshake; result 0x0007, error 0.
- Round-robin: ports 0 and 1 both hold valid continuously with SUB 0x0010-0x0001 and AND 0x00F0&0x0F0F -> grants alternate 0,1,0,1; responses are 0x000F on port0 and 0x0000 on port1.
- Divide-by-zero: port1 sends op 0x3, b=0x0000 -> alu_en_o never asserts; rsp_valid_o=10 next cycle; result 0x0000, error 1.
- Back-pressure: rsp_ready_i=0 for 5 cycles after a MUL 0x0002*0x0003 -> rsp_valid_o, result 0x0006 and error 0 held stable; req_ready_o stays 0 despite pending valids.
- Illegal op 0xC and NOP 0xF: illegal gives error=1, NOP gives error=0, both with result 0x0000 and no alu_en_o; ALU_LAT=3 rerun of the ADD case gives rsp_valid_o 5 cycles after handshake.
